j11_memarb: RTL and testbench

Two-master memory arbiter between the J11 bus interface's memory port (CPU side) and the RL disk controller's DMA port. It serialises both onto the single memory/DDR port, one outstanding transaction at a time. Arbitration is round-robin, and a response always returns only to the requester that issued the transaction. All request/ack signalling uses single-cycle pulses, matching the existing memreq/memack protocol.

---
 rtl/j11_memarb_if.sv | 48 ++++
 rtl/j11_memarb.sv | 169 ++++++++++++++++
 tb/tb_j11_memarb.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/j11_memarb_if.sv
// Bus bundle for the J11 memory arbiter: CPU and DMA requester ports plus the shared memory port.
// slave = arbiter view, master = requesters and memory model view.
interface j11_memarb_if;
   logic        cpu_req;
   logic        cpu_wr;
   logic [21:0] cpu_addr;
   logic [15:0] cpu_wdata;
   logic [1:0]  cpu_wstrb;
   logic        cpu_ack;
   logic [15:0] cpu_rdata;
   logic        cpu_err;

   logic        dma_req;
   logic        dma_wr;
   logic [21:0] dma_addr;
   logic [15:0] dma_wdata;
   logic [1:0]  dma_wstrb;
   logic        dma_ack;
   logic [15:0] dma_rdata;
   logic        dma_err;

   logic        mem_req;
   logic        mem_wr;
   logic [21:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [1:0]  mem_wstrb;
   logic        mem_ack;
   logic [15:0] mem_rdata;
   logic        mem_err;

   modport slave (
      input  cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
      output cpu_ack, cpu_rdata, cpu_err,
      input  dma_req, dma_wr, dma_addr, dma_wdata, dma_wstrb,
      output dma_ack, dma_rdata, dma_err,
      output mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
      input  mem_ack, mem_rdata, mem_err
   );

   modport master (
      output cpu_req, cpu_wr, cpu_addr, cpu_wdata, cpu_wstrb,
      input  cpu_ack, cpu_rdata, cpu_err,
      output dma_req, dma_wr, dma_addr, dma_wdata, dma_wstrb,
      input  dma_ack, dma_rdata, dma_err,
      input  mem_req, mem_wr, mem_addr, mem_wdata, mem_wstrb,
      output mem_ack, mem_rdata, mem_err
   );
endinterface

// File: rtl/j11_memarb.sv
// Round-robin CPU/DMA arbiter onto a single memory port, one transaction in flight.
// Define MEMARB_TIMEOUT_EN to abort a WAIT that exceeds TIMEOUT cycles with an error ack.
//
// state | meaning
// IDLE  | no transaction in flight; grant a pending slot if any
// ISSUE | mem_req pulse; mem_ack here completes the transaction early
// WAIT  | waiting for mem_ack (or timeout)
// DONE  | ack already delivered from ISSUE; one turnaround cycle
module j11_memarb #(
   parameter int TIMEOUT = 1023,
   parameter int TW      = 10
) (
   input logic         clk,
   input logic         rstn,
   j11_memarb_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   typedef struct packed {
      logic        wr;
      logic [21:0] addr;
      logic [15:0] wdata;
      logic [1:0]  wstrb;
   } xact_t;

   state_t      state, state_nx;
   xact_t       slot_cpu, slot_dma, mem_q;
   logic        pend_cpu, pend_dma;
   logic        grant_dma, last_dma;
   logic        grant_en, grant_dma_nx;
   logic        fin, fin_err;
   logic [15:0] fin_rdata;
   logic        busy, take_cpu, take_dma;
   logic        cpu_ack_q, cpu_err_q, dma_ack_q, dma_err_q;
   logic [15:0] cpu_rdata_q, dma_rdata_q;

   if (TIMEOUT < 1 || TIMEOUT >= (1 << TW)) begin : g_param_check
      $error("j11_memarb: TIMEOUT must be in 1 .. 2**TW-1");
   end

`ifdef MEMARB_TIMEOUT_EN
   logic [TW-1:0] tcnt;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         tcnt <= '0;
      else if (state == ISSUE)
         tcnt <= '0;
      else if (state == WAIT)
         tcnt <= tcnt + 1'b1;
   end
`endif

   // a requester is blocked only while its own transaction is outstanding
   assign busy     = (state == ISSUE) || (state == WAIT);
   assign take_cpu = bus.cpu_req && !pend_cpu && !(busy && !grant_dma);
   assign take_dma = bus.dma_req && !pend_dma && !(busy && grant_dma);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      grant_en     = 1'b0;
      grant_dma_nx = grant_dma;
      fin          = 1'b0;
      fin_err      = 1'b0;
      fin_rdata    = '0;
      unique case (state)
         IDLE: begin
            if (pend_cpu || pend_dma) begin
               grant_en     = 1'b1;
               grant_dma_nx = pend_dma && (!pend_cpu || !last_dma);
               state_nx     = ISSUE;
            end
         end
         ISSUE: begin
            if (bus.mem_ack) begin
               fin       = 1'b1;
               fin_err   = bus.mem_err;
               fin_rdata = bus.mem_rdata;
               state_nx  = DONE;
            end else begin
               state_nx = WAIT;
            end
         end
         WAIT: begin
            if (bus.mem_ack) begin
               fin       = 1'b1;
               fin_err   = bus.mem_err;
               fin_rdata = bus.mem_rdata;
               state_nx  = IDLE;
            end
`ifdef MEMARB_TIMEOUT_EN
            else if (tcnt == TW'(TIMEOUT - 1)) begin
               fin      = 1'b1;
               fin_err  = 1'b1;
               state_nx = IDLE;
            end
`endif
         end
         DONE: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pend_cpu    <= 1'b0;
         pend_dma    <= 1'b0;
         slot_cpu    <= '0;
         slot_dma    <= '0;
         mem_q       <= '0;
         grant_dma   <= 1'b0;
         last_dma    <= 1'b1;
         cpu_ack_q   <= 1'b0;
         cpu_err_q   <= 1'b0;
         cpu_rdata_q <= '0;
         dma_ack_q   <= 1'b0;
         dma_err_q   <= 1'b0;
         dma_rdata_q <= '0;
      end else begin
         if (grant_en) begin
            grant_dma <= grant_dma_nx;
            last_dma  <= grant_dma_nx;
            if (grant_dma_nx) begin
               mem_q    <= slot_dma;
               pend_dma <= 1'b0;
            end else begin
               mem_q    <= slot_cpu;
               pend_cpu <= 1'b0;
            end
         end
         if (take_cpu) begin
            pend_cpu <= 1'b1;
            slot_cpu <= {bus.cpu_wr, bus.cpu_addr, bus.cpu_wdata, bus.cpu_wstrb};
         end
         if (take_dma) begin
            pend_dma <= 1'b1;
            slot_dma <= {bus.dma_wr, bus.dma_addr, bus.dma_wdata, bus.dma_wstrb};
         end
         cpu_ack_q <= fin && !grant_dma;
         dma_ack_q <= fin && grant_dma;
         if (fin && !grant_dma) begin
            cpu_rdata_q <= fin_rdata;
            cpu_err_q   <= fin_err;
         end
         if (fin && grant_dma) begin
            dma_rdata_q <= fin_rdata;
            dma_err_q   <= fin_err;
         end
      end
   end

   assign bus.mem_req   = (state == ISSUE);
   assign bus.mem_wr    = mem_q.wr;
   assign bus.mem_addr  = mem_q.addr;
   assign bus.mem_wdata = mem_q.wdata;
   assign bus.mem_wstrb = mem_q.wstrb;
   assign bus.cpu_ack   = cpu_ack_q;
   assign bus.cpu_rdata = cpu_rdata_q;
   assign bus.cpu_err   = cpu_err_q;
   assign bus.dma_ack   = dma_ack_q;
   assign bus.dma_rdata = dma_rdata_q;
   assign bus.dma_err   = dma_err_q;
endmodule

// File: tb/tb_j11_memarb.sv
// Directed bench for j11_memarb: latency, round-robin, write hold, early ack, reset abort, timeout.
// Inputs change 1 time unit after posedge; outputs are sampled at that same point.
module tb_j11_memarb;
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;

   j11_memarb_if bus();

`ifdef MEMARB_TIMEOUT_EN
   j11_memarb #(.TIMEOUT(8), .TW(10)) dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
`else
   j11_memarb dut (.clk(clk), .rstn(rstn), .bus(bus.slave));
`endif

   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_inputs();
      bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wstrb = '0;
      bus.dma_req = 0; bus.dma_wr = 0; bus.dma_addr = '0; bus.dma_wdata = '0; bus.dma_wstrb = '0;
      bus.mem_ack = 0; bus.mem_rdata = '0; bus.mem_err = 0;
   endtask

   task automatic drive_cpu(input logic wr, input logic [21:0] a, input logic [15:0] d, input logic [1:0] s);
      bus.cpu_req = 1; bus.cpu_wr = wr; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = s;
   endtask

   task automatic drive_dma(input logic wr, input logic [21:0] a, input logic [15:0] d, input logic [1:0] s);
      bus.dma_req = 1; bus.dma_wr = wr; bus.dma_addr = a; bus.dma_wdata = d; bus.dma_wstrb = s;
   endtask

   task automatic drop_reqs();
      bus.cpu_req = 0;
      bus.dma_req = 0;
   endtask

   // returns the cycle in which mem_req is seen, or -1 if none within the budget
   task automatic wait_mem_req(output int t);
      t = -1;
      for (int i = 0; i < 40; i++) begin
         if (bus.mem_req) begin
            t = cyc;
            return;
         end
         step();
      end
   endtask

   task automatic wait_ack(input bit dma, output int t);
      t = -1;
      for (int i = 0; i < 40; i++) begin
         if (dma ? bus.dma_ack : bus.cpu_ack) begin
            t = cyc;
            return;
         end
         step();
      end
   endtask

   // called in the ISSUE cycle; acks in the first WAIT cycle, returns in the requester-ack cycle
   task automatic serve(input logic [15:0] rd, input logic err);
      step();
      bus.mem_ack = 1; bus.mem_rdata = rd; bus.mem_err = err;
      step();
      bus.mem_ack = 0; bus.mem_err = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rstn = 0;
      step(); step();
      n_cmp++;
      if ({bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== 42'h0) begin
         n_bad++; $display("FAIL reset_mem: got %h want 0", {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb});
      end
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack, bus.dma_rdata, bus.dma_err} !== 36'h0) begin
         n_bad++; $display("FAIL reset_resp: got %h want 0", {bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack, bus.dma_rdata, bus.dma_err});
      end
      rstn = 1;
      step(); step();
      n_cmp++;
      if (bus.mem_req !== 1'b0) begin
         n_bad++; $display("FAIL reset_idle_memreq: got %b want 0", bus.mem_req);
      end
   endtask

   task automatic test_single_read();
      int c0;
      c0 = cyc;
      drive_cpu(0, 22'o17770000, 16'h0, 2'b11);
      step(); drop_reqs();
      n_cmp++;
      if (bus.mem_req !== 1'b0) begin
         n_bad++; $display("FAIL single_c1_memreq: got %b want 0", bus.mem_req);
      end
      step();
      n_cmp++;
      if ({bus.mem_req, bus.mem_wr, bus.mem_addr} !== {1'b1, 1'b0, 22'o17770000}) begin
         n_bad++; $display("FAIL single_c2_issue: got req=%b wr=%b addr=%o want 1 0 17770000", bus.mem_req, bus.mem_wr, bus.mem_addr);
      end
      step();
      n_cmp++;
      if (bus.mem_req !== 1'b0) begin
         n_bad++; $display("FAIL single_c3_memreq: got %b want 0", bus.mem_req);
      end
      step(); step();
      bus.mem_ack = 1; bus.mem_rdata = 16'o123456;
      step();
      bus.mem_ack = 0;
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack} !== {1'b1, 16'o123456, 1'b0, 1'b0} || cyc - c0 != 6) begin
         n_bad++; $display("FAIL single_c6_ack: got ack=%b rdata=%o err=%b dma_ack=%b cycle=%0d want 1 123456 0 0 cycle 6",
                           bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack, cyc - c0);
      end
      step();
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b0, 16'o123456}) begin
         n_bad++; $display("FAIL single_c7_hold: got ack=%b rdata=%o want 0 123456", bus.cpu_ack, bus.cpu_rdata);
      end
   endtask

   task automatic test_round_robin();
      int t, t0;
      rstn = 0; step(); rstn = 1; step();
      drive_cpu(0, 22'd100, 16'h0, 2'b11);
      drive_dma(0, 22'd200, 16'h0, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      n_cmp++;
      if (t == -1 || bus.mem_addr !== 22'd100) begin
         n_bad++; $display("FAIL rr1_first: got t=%0d addr=%0d want cpu addr 100", t, bus.mem_addr);
      end
      serve(16'h1111, 0);
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata, bus.dma_ack} !== {1'b1, 16'h1111, 1'b0}) begin
         n_bad++; $display("FAIL rr1_cpu_ack: got ack=%b rdata=%h dma_ack=%b want 1 1111 0", bus.cpu_ack, bus.cpu_rdata, bus.dma_ack);
      end
      step();
      n_cmp++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 22'd200}) begin
         n_bad++; $display("FAIL rr1_second: got req=%b addr=%0d want 1 200", bus.mem_req, bus.mem_addr);
      end
      serve(16'h2222, 0);
      n_cmp++;
      if ({bus.dma_ack, bus.dma_rdata, bus.cpu_ack} !== {1'b1, 16'h2222, 1'b0}) begin
         n_bad++; $display("FAIL rr1_dma_ack: got ack=%b rdata=%h cpu_ack=%b want 1 2222 0", bus.dma_ack, bus.dma_rdata, bus.cpu_ack);
      end
      // CPU alone: last grant becomes CPU, so the next tie goes to DMA
      drive_cpu(0, 22'd300, 16'h0, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      serve(16'h3333, 0);
      t0 = cyc;
      drive_cpu(0, 22'd400, 16'h0, 2'b11);
      drive_dma(1, 22'd500, 16'h5555, 2'b10);
      step(); drop_reqs();
      wait_mem_req(t);
      n_cmp++;
      if (t != t0 + 2 || {bus.mem_addr, bus.mem_wr} !== {22'd500, 1'b1}) begin
         n_bad++; $display("FAIL rr3_dma_first: got t=%0d addr=%0d wr=%b want t=%0d addr 500 wr 1", t, bus.mem_addr, bus.mem_wr, t0 + 2);
      end
      serve(16'h0, 0);
      wait_mem_req(t);
      n_cmp++;
      if (t == -1 || bus.mem_addr !== 22'd400) begin
         n_bad++; $display("FAIL rr3_cpu_second: got t=%0d addr=%0d want addr 400", t, bus.mem_addr);
      end
      serve(16'h4444, 0);
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'h4444}) begin
         n_bad++; $display("FAIL rr3_cpu_ack: got ack=%b rdata=%h want 1 4444", bus.cpu_ack, bus.cpu_rdata);
      end
   endtask

   task automatic test_dma_write();
      int t;
      logic [40:0] exp_bus;
      exp_bus = {1'b1, 22'h2AAAA, 16'hBEEF, 2'b01};
      drive_dma(1, 22'h2AAAA, 16'hBEEF, 2'b01);
      step(); drop_reqs();
      wait_mem_req(t);
      n_cmp++;
      if (t == -1 || {bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== exp_bus) begin
         n_bad++; $display("FAIL dmaw_issue: got %h want %h", {bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, exp_bus);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb} !== {1'b0, exp_bus}) begin
            n_bad++; $display("FAIL dmaw_hold%0d: got %h want %h", i, {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, {1'b0, exp_bus});
         end
      end
      bus.mem_ack = 1; bus.mem_err = 1; bus.mem_rdata = 16'h0;
      step();
      bus.mem_ack = 0; bus.mem_err = 0;
      n_cmp++;
      if ({bus.dma_ack, bus.dma_err, bus.cpu_ack} !== 3'b110) begin
         n_bad++; $display("FAIL dmaw_err_ack: got ack=%b err=%b cpu_ack=%b want 1 1 0", bus.dma_ack, bus.dma_err, bus.cpu_ack);
      end
   endtask

   task automatic test_zero_latency();
      int t, n_ack, n_req;
      drive_cpu(0, 22'o777, 16'h0, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      bus.mem_ack = 1; bus.mem_rdata = 16'h5A5A;
      step();
      bus.mem_ack = 0;
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata, bus.cpu_err} !== {1'b1, 16'h5A5A, 1'b0}) begin
         n_bad++; $display("FAIL zl_ack: got ack=%b rdata=%h err=%b want 1 5a5a 0", bus.cpu_ack, bus.cpu_rdata, bus.cpu_err);
      end
      n_ack = 0; n_req = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_ack += int'(bus.cpu_ack) + int'(bus.dma_ack);
         n_req += int'(bus.mem_req);
      end
      n_cmp++;
      if (n_ack != 0 || n_req != 0) begin
         n_bad++; $display("FAIL zl_no_dup: got acks=%0d mem_reqs=%0d want 0 0", n_ack, n_req);
      end
   endtask

   task automatic test_reset_in_wait();
      int t, n_ack, n_req;
      drive_cpu(1, 22'h3FFFFF, 16'hFFFF, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      step(); step();
      rstn = 0;
      #2;
      n_cmp++;
      if ({bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb,
           bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack, bus.dma_rdata, bus.dma_err} !== 78'h0) begin
         n_bad++; $display("FAIL rstwait_outputs: got mem=%h resp=%h want 0",
                           {bus.mem_req, bus.mem_wr, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                           {bus.cpu_ack, bus.cpu_rdata, bus.cpu_err, bus.dma_ack, bus.dma_rdata, bus.dma_err});
      end
      @(posedge clk); #1; cyc++;
      rstn = 1;
      step();
      bus.mem_ack = 1; bus.mem_rdata = 16'hDEAD;
      step();
      bus.mem_ack = 0;
      n_ack = 0; n_req = 0;
      for (int i = 0; i < 5; i++) begin
         n_ack += int'(bus.cpu_ack) + int'(bus.dma_ack);
         n_req += int'(bus.mem_req);
         step();
      end
      n_cmp++;
      if (n_ack != 0 || n_req != 0) begin
         n_bad++; $display("FAIL rstwait_late_ack: got acks=%0d mem_reqs=%0d want 0 0", n_ack, n_req);
      end
      drive_cpu(0, 22'o1000, 16'h0, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      n_cmp++;
      if (t == -1 || bus.mem_addr !== 22'o1000) begin
         n_bad++; $display("FAIL rstwait_next_issue: got t=%0d addr=%o want addr 1000", t, bus.mem_addr);
      end
      serve(16'h0C0C, 0);
      n_cmp++;
      if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b1, 16'h0C0C}) begin
         n_bad++; $display("FAIL rstwait_next_ack: got ack=%b rdata=%h want 1 0c0c", bus.cpu_ack, bus.cpu_rdata);
      end
   endtask

   task automatic test_timeout();
      int t, ta;
      drive_cpu(0, 22'o2000, 16'h0, 2'b11);
      step(); drop_reqs();
      wait_mem_req(t);
      step();
      drive_dma(0, 22'o1234, 16'h0, 2'b11);
      step(); drop_reqs();
`ifdef MEMARB_TIMEOUT_EN
      wait_ack(0, ta);
      n_cmp++;
      if (ta == -1 || ta - (t + 1) != 8) begin
         n_bad++; $display("FAIL to_ack_time: got %0d cycles after WAIT entry want 8", (ta == -1) ? -1 : ta - (t + 1));
      end
      n_cmp++;
      if ({bus.cpu_err, bus.cpu_rdata, bus.dma_ack} !== {1'b1, 16'h0, 1'b0}) begin
         n_bad++; $display("FAIL to_ack_err: got err=%b rdata=%h dma_ack=%b want 1 0000 0", bus.cpu_err, bus.cpu_rdata, bus.dma_ack);
      end
      wait_mem_req(t);
      n_cmp++;
      if (t == -1 || bus.mem_addr !== 22'o1234) begin
         n_bad++; $display("FAIL to_dma_issue: got t=%0d addr=%o want addr 1234", t, bus.mem_addr);
      end
      serve(16'h7777, 0);
      n_cmp++;
      if ({bus.dma_ack, bus.dma_rdata, bus.dma_err} !== {1'b1, 16'h7777, 1'b0}) begin
         n_bad++; $display("FAIL to_dma_ack: got ack=%b rdata=%h err=%b want 1 7777 0", bus.dma_ack, bus.dma_rdata, bus.dma_err);
      end
`else
      begin
         int n_ack, n_req;
         n_ack = 0; n_req = 0;
         for (int i = 0; i < 40; i++) begin
            n_ack += int'(bus.cpu_ack) + int'(bus.dma_ack);
            n_req += int'(bus.mem_req);
            step();
         end
         ta = n_ack;
         n_cmp++;
         if (ta != 0 || n_req != 0) begin
            n_bad++; $display("FAIL noto_hang: got acks=%0d mem_reqs=%0d want 0 0", ta, n_req);
         end
      end
`endif
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_round_robin();
      test_dma_write();
      test_zero_latency();
      test_reset_in_wait();
      test_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
